// File: rtl/psum_drain_if.sv
// Buffer read port and output row stream of the psum readout sequencer.
// The master side is the sequencer; the slave side is buffer plus downstream sink.
interface psum_drain_if #(
  parameter int unsigned ARRAY_DIM  = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]           rd_addr;
  logic [ARRAY_DIM*ACC_WIDTH-1:0]  rd_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [ARRAY_DIM*OUT_WIDTH-1:0]  out_data;
  logic                            out_last;

  modport master (
    output rd_addr, out_valid, out_data, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_addr, out_valid, out_data, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/psum_drain.sv
// Partial-sum buffer readout: walks a wrapping row range, post-processes each row
// (ReLU, rounding shift, saturation) and streams it out through a credit-managed FIFO.
module psum_drain #(
  parameter int unsigned ARRAY_DIM  = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_rows,
  input  logic [4:0]            shift,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  psum_drain_if.master          bus
);
  localparam int unsigned RowW = ARRAY_DIM * OUT_WIDTH;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic signed [ACC_WIDTH:0] SatMax = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state_q;
  logic                  busy_q, done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic [4:0]            shift_q;
  logic                  relu_q;
  logic                  inflight_q, inflight_last_q;

  logic [RowW-1:0]       fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic                  fifo_valid, head_last, pop, push, issue;
  logic [CntW:0]         outstanding;
  logic [RowW-1:0]       proc_row;

  // Lane math in ACC_WIDTH+1 bits so the rounding add cannot overflow.
  function automatic logic [OUT_WIDTH-1:0] proc_lane(input logic [ACC_WIDTH-1:0] lane,
                                                     input logic [4:0]           sh,
                                                     input logic                 relu);
    logic signed [ACC_WIDTH:0] x, rnd, y;
    x = signed'({lane[ACC_WIDTH-1], lane});
    if (relu && x < 0) x = '0;
    rnd = (sh == 5'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (sh - 5'd1));
    y = (x + rnd) >>> sh;
    if (y > SatMax) y = SatMax;
    else if (y < SatMin) y = SatMin;
    return y[OUT_WIDTH-1:0];
  endfunction

  always_comb begin
    proc_row = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      proc_row[i*OUT_WIDTH +: OUT_WIDTH] =
        proc_lane(bus.rd_data[i*ACC_WIDTH +: ACC_WIDTH], shift_q, relu_q);
    end
  end

  assign fifo_valid  = (count_q != '0);
  assign head_last   = fifo_last_q[rd_ptr_q];
  assign pop         = fifo_valid && bus.out_ready;
  assign push        = inflight_q;
  // Credit counts the read still in flight so the FIFO can always absorb it.
  assign outstanding = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign issue       = (state_q == StIssue) && (outstanding < (CntW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      addr_q          <= '0;
      remain_q        <= '0;
      shift_q         <= '0;
      relu_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && (remain_q == (ADDR_WIDTH+1)'(1));
      done_q          <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q   <= base_addr;
            remain_q <= num_rows;
            shift_q  <= shift;
            relu_q   <= relu_en;
            if (num_rows != '0) begin
              state_q <= StIssue;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (issue) begin
            addr_q   <= addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (remain_q == (ADDR_WIDTH+1)'(1)) state_q <= StDrain;
          end
        end
        StDrain: begin
          // The tagged last row leaving the FIFO implies nothing is in flight or queued.
          if (pop && head_last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_last_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= proc_row;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.rd_addr   = addr_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.out_last  = fifo_valid && head_last;

endmodule

// File: tb/tb_psum_drain.sv
// Randomized bench for psum_drain: job-level reference model (expected-row queue,
// busy/done expectations) checked every cycle, plus literal directed checks.
module tb_psum_drain;
  localparam int DIM = 16;
  localparam int AW  = 10;
  localparam int FD  = 4;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic [4:0]    shift;
  logic          relu_en;
  logic          busy, done;

  psum_drain_if #(.ARRAY_DIM(16), .ACC_WIDTH(32), .OUT_WIDTH(8), .ADDR_WIDTH(10)) bus ();

  psum_drain #(
    .ARRAY_DIM(16), .ACC_WIDTH(32), .OUT_WIDTH(8), .ADDR_WIDTH(10), .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .num_rows (num_rows),
    .shift    (shift),
    .relu_en  (relu_en),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [511:0] mem [0:1023];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  int ready_mode = 0;
  int rcyc = 0;
  always @(posedge clk) begin
    #1;
    rcyc++;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (rcyc % 3 == 0);
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_lane(input int lane, input int sh, input bit relu);
    longint x;
    x = longint'(lane);
    if (relu && x < 0) x = 0;
    if (sh > 0) x = (x + (longint'(1) << (sh - 1))) >>> sh;
    if (x > 127) x = 127;
    else if (x < -128) x = -128;
    return x[7:0];
  endfunction

  function automatic logic [127:0] ref_row(input logic [511:0] r, input int sh, input bit relu);
    logic [127:0] res;
    for (int l = 0; l < DIM; l++) res[l*8 +: 8] = ref_lane(int'($signed(r[l*32 +: 32])), sh, relu);
    return res;
  endfunction

  // Job-level model state
  beat_t        q[$];
  bit           m_busy = 0, m_done = 0, busy_n, done_n;
  bit           prev_stall = 0, prev_busy = 0, prev_last;
  logic [127:0] prev_data;
  logic [AW-1:0] prev_rd;
  int           job_issued = 0, job_accepted = 0, job_rows = 0;
  beat_t        h;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy",  128'(busy), 128'(0));
      check("rst_done",  128'(done), 128'(0));
      check("rst_valid", 128'(bus.out_valid), 128'(0));
      check("rst_last",  128'(bus.out_last), 128'(0));
      check("rst_data",  128'(bus.out_data), 128'(0));
      check("rst_addr",  128'(bus.rd_addr), 128'(0));
      q.delete();
      m_busy = 0; m_done = 0; prev_stall = 0; prev_busy = 0;
      job_issued = 0; job_accepted = 0;
    end else begin
      busy_n = m_busy;
      done_n = 0;
      check("busy", 128'(busy), 128'(m_busy));
      check("done", 128'(done), 128'(m_done));
      if (prev_stall) begin
        check("hold_valid", 128'(bus.out_valid), 128'(1));
        check("hold_data",  128'(bus.out_data), prev_data);
        check("hold_last",  128'(bus.out_last), 128'(prev_last));
      end
      if (prev_busy && bus.rd_addr != prev_rd) job_issued++;
      if (m_busy) check("outstanding_le_depth", 128'((job_issued - job_accepted) <= FD), 128'(1));
      if (q.size() == 0) check("spurious_beat", 128'(bus.out_valid), 128'(0));
      else if (bus.out_valid) begin
        check("beat_data", bus.out_data, q[0].data);
        check("beat_last", 128'(bus.out_last), 128'(q[0].last));
        if (bus.out_ready) begin
          h = q.pop_front();
          job_accepted++;
          if (h.last) begin
            check("issue_count", 128'(job_issued), 128'(job_rows));
            busy_n = 0;
            done_n = 1;
          end
        end
      end
      if (!m_busy && !m_done && start) begin
        job_rows = int'(num_rows);
        job_issued = 0;
        job_accepted = 0;
        if (num_rows == 0) done_n = 1;
        else begin
          busy_n = 1;
          for (int k = 0; k < job_rows; k++) begin
            q.push_back('{ref_row(mem[(int'(base_addr) + k) % 1024], int'(shift), relu_en),
                          k == job_rows - 1});
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      prev_busy  = busy;
      prev_rd    = bus.rd_addr;
      m_busy     = busy_n;
      m_done     = done_n;
    end
  end

  task automatic set_row(input int a, input int v);
    for (int l = 0; l < DIM; l++) mem[a][l*32 +: 32] = v;
  endtask

  task automatic rand_row(input int a);
    int v;
    for (int l = 0; l < DIM; l++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom);
      else v = int'($urandom_range(0, 4000)) - 2000;
      mem[a][l*32 +: 32] = v;
    end
  endtask

  task automatic launch(input int b, input int n, input int sh, input bit rl);
    @(posedge clk);
    #1;
    base_addr = b[AW-1:0];
    num_rows  = n[AW:0];
    shift     = sh[4:0];
    relu_en   = rl;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!busy && !done && !m_busy && !m_done) break;
    end
    check("job_idle_in_time", {124'b0, busy, done, m_busy, m_done}, 128'(0));
  endtask

  task automatic wait_valid(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check("beat_in_time", 128'(bus.out_valid), 128'(1));
  endtask

  logic [127:0] e;
  int           v;

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; shift = '0; relu_en = 1'b0;
    for (int a = 0; a < 1024; a++) rand_row(a);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(bus.out_valid), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    rst_n = 1'b1;

    // Pin the reference lane function to hand-computed values
    check("model_40",   128'(ref_lane(40, 4, 0)),    128'(8'h03));
    check("model_24",   128'(ref_lane(24, 4, 0)),    128'(8'h02));
    check("model_m24",  128'(ref_lane(-24, 4, 0)),   128'(8'hFF));
    check("model_5000", 128'(ref_lane(5000, 4, 0)),  128'(8'h7F));
    check("model_m5k",  128'(ref_lane(-5000, 4, 0)), 128'(8'h80));
    check("model_relu", 128'(ref_lane(-24, 4, 1)),   128'(8'h00));

    // Directed latency test: rows 5..8 hold 1..4 in every lane
    for (int k = 0; k < 4; k++) set_row(5 + k, k + 1);
    launch(5, 4, 0, 0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 4) check("t1_rd_addr", 128'(bus.rd_addr), 128'(4 + c));
      check("t1_valid", 128'(bus.out_valid), 128'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        v = c - 2;
        for (int l = 0; l < DIM; l++) e[l*8 +: 8] = v[7:0];
        check("t1_data", bus.out_data, e);
        check("t1_last", 128'(bus.out_last), 128'(c == 6));
      end
      check("t1_done", 128'(done), 128'(c == 7));
    end
    wait_idle(50);

    // Arithmetic lanes, relu off then on
    set_row(100, 0);
    mem[100][31:0] = 32'd40;     mem[100][63:32] = 32'd24;  mem[100][95:64] = -32'sd24;
    mem[100][127:96] = 32'd5000; mem[100][159:128] = -32'sd5000;
    launch(100, 1, 4, 0);
    wait_valid(10);
    e = '0; e[7:0] = 8'h03; e[15:8] = 8'h02; e[23:16] = 8'hFF; e[31:24] = 8'h7F; e[39:32] = 8'h80;
    check("arith_lanes", bus.out_data, e);
    wait_idle(50);
    launch(100, 1, 4, 1);
    wait_valid(10);
    e = '0; e[7:0] = 8'h03; e[15:8] = 8'h02; e[31:24] = 8'h7F;
    check("arith_relu_lanes", bus.out_data, e);
    wait_idle(50);

    // Address wrap
    launch(1022, 4, 3, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("wrap_rd_addr", 128'(bus.rd_addr), 128'((1021 + c) % 1024));
    end
    wait_idle(50);

    // Back-pressure, ready one cycle in three
    ready_mode = 1;
    launch(200, 8, 2, 1);
    wait_idle(200);
    ready_mode = 0;

    // Zero-row job
    launch(7, 0, 0, 0);
    @(negedge clk);
    check("zero_done", 128'(done), 128'(1));
    check("zero_busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("zero_done_once", 128'(done), 128'(0));
    check("zero_no_beat", 128'(bus.out_valid), 128'(0));
    wait_idle(10);

    // Start pulsed while busy must be ignored
    ready_mode = 2;
    launch(300, 6, 1, 1);
    @(posedge clk);
    #1;
    base_addr = '0; num_rows = 11'd3; shift = 5'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(200);

    // Randomized jobs
    for (int j = 0; j < 14; j++) begin
      ready_mode = int'($urandom_range(0, 2));
      for (int a = 0; a < 8; a++) rand_row(int'($urandom_range(0, 1023)));
      launch(int'($urandom_range(0, 1023)),
             ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)),
             int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      wait_idle(2000);
    end

    // Reset mid-job with two rows queued, then a fresh job
    ready_mode = 3;
    launch(400, 8, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_data",  128'(bus.out_data), 128'(0));
    check("midrst_busy",  128'(busy), 128'(0));
    check("midrst_addr",  128'(bus.rd_addr), 128'(0));
    check("midrst_last",  128'(bus.out_last), 128'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    ready_mode = 0;
    rand_row(400);
    rand_row(401);
    launch(400, 2, 0, 0);
    wait_idle(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/psum_drain.md
# psum_drain

Readout sequencer for the partial-sum buffer's independent read port. On `start` it walks a contiguous, wrapping range of buffer rows and absorbs the buffer's 1-cycle registered read latency. Each 16-lane row is post-processed (optional ReLU, rounding arithmetic shift, signed saturation) into a narrow output row. Rows leave on a valid/ready stream toward the output/writeback path, with a small credit-managed FIFO so downstream back-pressure never drops a row.

## Interface
Parameters:
- `ARRAY_DIM`, 16, lanes per buffer row
- `ACC_WIDTH`, 32, signed psum lane width
- `OUT_WIDTH`, 8, signed output lane width
- `ADDR_WIDTH`, 10, buffer address width
- `FIFO_DEPTH`, 4, output FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  launch pulse, sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  first row address
- `num_rows`  in  ADDR_WIDTH+1  rows to drain, 0..2^ADDR_WIDTH
- `shift`  in  5  right-shift amount, 0..31
- `relu_en`  in  1  clamp negative lanes to 0 before shift
- `busy`  out  1  high from the cycle after accepted start until DONE
- `done`  out  1  one-cycle pulse at completion
- `rd_addr`  out  ADDR_WIDTH  to buffer `read_addr`
- `rd_data`  in  ARRAY_DIM*ACC_WIDTH  from buffer `read_data`, valid 1 cycle after address
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready
- `out_data`  out  ARRAY_DIM*OUT_WIDTH  processed row, lane i at bits [i*OUT_WIDTH +: OUT_WIDTH]
- `out_last`  out  1  high with final row of the job

## Operation
- FSM states:
  - IDLE: on `start`, latch `base_addr`, `num_rows`, `shift`, `relu_en`. If `num_rows`≠0, go to ISSUE; else go to DONE.
  - ISSUE: issue one read per cycle when credit is available. After the last issue, go to DRAIN.
  - DRAIN: wait until no read is in flight, FIFO is empty, and the last beat has been accepted. Then go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored outside IDLE. Latched parameters are held for the whole job.
- Issue:
  - Issue happens in a cycle where state=ISSUE and `count + inflight < FIFO_DEPTH`. `count` is FIFO occupancy before this cycle's pop; `inflight` is the read issued last cycle (0/1).
  - The address on `rd_addr` in an issue cycle is the address read. It advances by 1 modulo 2^ADDR_WIDTH per issue (wraps 1023→0).
  - `rd_addr` holds its value when not issuing.
- Capture: in the cycle after an issue, `rd_data` is processed and pushed into the FIFO at the clock edge. The credit rule guarantees the FIFO is never overflowed.
- Per-lane arithmetic, computed in ACC_WIDTH+1 signed bits:
  - x = lane as signed.
  - If `relu_en` and x<0, x=0.
  - If shift>0, y = (x + 2^(shift-1)) >>> shift (round half up); else y = x.
  - Saturate y to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- FIFO: show-ahead. `out_valid` = not empty; `out_data`/`out_last` come from the head entry. Pop on `out_valid && out_ready`. Simultaneous push and pop keeps the count unchanged.
- `out_last` is stored with the row whose index is `num_rows`-1.
- Stream rule: once `out_valid`=1, `out_data` and `out_last` stay stable until the beat is accepted.

## Timing
- Reset (async assert, any state): state=IDLE, FIFO empty, inflight=0. `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `rd_addr`=0.
- Reset mid-job abandons the job. No `done` is produced. The next `start` is accepted normally.
- With `start` sampled at edge E0:
  - `rd_addr`=base during cycle 1.
  - The row is pushed at edge E2.
  - `out_valid`=1 in cycle 3. Start-to-first-beat latency is 3 cycles.
- With `out_ready` held high: 1 row/cycle; last beat in cycle N+2; `done` in cycle N+3 for N rows.
- With `num_rows`=0: `busy` stays 0 and `done` pulses in the cycle after `start`. No reads, no beats.
- `out_ready` low: at most FIFO_DEPTH rows outstanding, counting FIFO plus in-flight; issue stalls and `rd_addr` holds. Throughput resumes at 1 row/cycle after ready returns.
- The FIFO and output path are independent of the FSM state. Beats drain in DRAIN regardless.

## Test plan
- base=5, rows=4, shift=0, relu off, ready high, mem[5..8] lanes = 1,2,3,4 → `rd_addr` 5,6,7,8 in consecutive cycles; beats 1,2,3,4 in cycles 3–6; `out_last` on the 4th; `done` in cycle 7.
- Back-pressure: rows=8, `out_ready` toggling 1-of-3 cycles → 8 beats in address order, no loss or duplication, payload stable while valid&&!ready, outstanding never >4.
- Arithmetic lanes with shift=4, relu off: 40→3 (40+8=48>>4), 24→2, -24→-1, 5000→127, -5000→-128. With relu on, -24→0.
- Wrap: base=1022, rows=4 → addresses 1022,1023,0,1; `out_last` on the row from address 1.
- rows=0 → `done` one cycle after `start`, no `out_valid`. `start` pulsed while busy → ignored, job unaffected.
- Assert `rst_n` low with 2 rows queued mid-job → all outputs 0 immediately. A new job after release (rows=2) completes correctly with fresh data only.
